multicycle_maindec: RTL and testbench

Multicycle main controller for the MIPS core. It is the sequential successor to the single-cycle main decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK states per instruction.
- Inserts parametrised memory wait states.
- Hands FP ops to a variable-latency FPU via a start/done handshake.
- Sits between the instruction register (op/funct) and the shared-memory multicycle datapath.

---
 rtl/multicycle_maindec.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec.sv
// -----------------------------------------------------------------------------
// multicycle_maindec
//
// Main controller for the multicycle MIPS core. It walks each instruction
// through FETCH / DECODE / EXECUTE / MEM / WRITEBACK states. Memory states
// last MEM_WAIT+1 cycles. FP instructions are handed to a variable-latency
// FPU through a start/done handshake.
//
// Optional feature macro: FP_TIMEOUT_EN
//   defined   : FPWAIT aborts to FETCH after FP_TIMEOUT cycles without
//               fpu_done and sets the sticky fp_err flag.
//   undefined : FPWAIT waits indefinitely and fp_err is tied to 0.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   op, funct     opcode / funct fields from the instruction register
//   zero          ALU zero flag (feeds pcen combinationally)
//   fpu_done      one-cycle FPU result-valid pulse
//   pcwrite, pcen unconditional PC load / effective PC enable
//   iord          memory address select (1 = ALUOut)
//   memwrite      memory write strobe
//   irwrite       instruction register load
//   regdst        destination select: 00 rt, 01 rd, 10 $31
//   memtoreg      write back from the data register
//   regwrite      integer register write
//   alusrca       ALU A select: 0 PC, 1 rs
//   alusrcb       ALU B select: 00 rt, 01 4, 10 signext imm, 11 imm<<2
//   zeroext       zero-extend the immediate (ORI/ANDI)
//   pcsrc         PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   aluop         0000 add, 0001 sub, 0011 or, 0111 and, 1111 decode funct
//   fpu_start     one-cycle FPU launch pulse
//   fpu_control   FPU operation, valid while fpu_start = 1
//   fp_regwrite   FP register write
//   illegal       sticky illegal-opcode flag
//   fp_err        sticky FPU timeout flag
// -----------------------------------------------------------------------------
module multicycle_maindec #(
    parameter int MEM_WAIT   = 1,
    parameter int FP_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       fpu_done,
    output logic       pcwrite,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [3:0] aluop,
    output logic       fpu_start,
    output logic [3:0] fpu_control,
    output logic       fp_regwrite,
    output logic       illegal,
    output logic       fp_err
);

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_RTEX, S_RTWB, S_IMMEX, S_IMMWB, S_BR, S_JMP, S_JR,
        S_FPSTART, S_FPWAIT, S_FPWB, S_ILL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_FP    = 6'b010001;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    // The counter only ever needs to reach the largest value it is compared
    // against, so it saturates there instead of at all-ones.
    localparam int               CNT_SAT_I = (MEM_WAIT > FP_TIMEOUT - 1) ? MEM_WAIT : FP_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_SAT_I);
    localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_WAIT);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_last;
    logic             branch;
    logic             fp_timeout;
    logic             illegal_q;

    assign mem_last = (cnt == MEM_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (cnt != CNT_SAT)
                cnt <= cnt + CNT_W'(1);
            if (state_next == S_ILL)
                illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

`ifdef FP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FP_TIMEOUT - 1);
    logic fp_err_q;

    // fpu_done arriving in the last allowed cycle still wins over the abort.
    assign fp_timeout = (state == S_FPWAIT) && (cnt == FP_LAST) && !fpu_done;

    always_ff @(posedge clk) begin
        if (reset)
            fp_err_q <= 1'b0;
        else if (fp_timeout)
            fp_err_q <= 1'b1;
    end

    assign fp_err = fp_err_q;
`else
    assign fp_timeout = 1'b0;
    assign fp_err     = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (mem_last) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:               state_next = S_MEMADR;
                    OP_RTYPE:                   state_next = (funct == FN_JR) ? S_JR : S_RTEX;
                    OP_BEQ, OP_BNE:             state_next = S_BR;
                    OP_ADDI, OP_ORI, OP_ANDI:   state_next = S_IMMEX;
                    OP_J, OP_JAL:               state_next = S_JMP;
                    OP_FP:                      state_next = (funct < 6'd4) ? S_FPSTART : S_ILL;
                    default:                    state_next = S_ILL;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_last) state_next = S_MEMWB;
            S_MEMWR:   if (mem_last) state_next = S_FETCH;
            S_RTEX:    state_next = S_RTWB;
            S_IMMEX:   state_next = S_IMMWB;
            S_FPSTART: state_next = S_FPWAIT;
            S_FPWAIT: begin
                if (fpu_done)
                    state_next = S_FPWB;
                else if (fp_timeout)
                    state_next = S_FETCH;
            end
            S_ILL:     state_next = S_ILL;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 2'b00;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        zeroext     = 1'b0;
        pcsrc       = 2'b00;
        aluop       = ALU_ADD;
        fpu_start   = 1'b0;
        fpu_control = 4'b0000;
        fp_regwrite = 1'b0;
        branch      = 1'b0;

        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_last;
                pcwrite = mem_last;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_last;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_RTWB: begin
                regdst   = 2'b01;
                regwrite = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ORI:  begin aluop = ALU_OR;  zeroext = 1'b1; end
                    OP_ANDI: begin aluop = ALU_AND; zeroext = 1'b1; end
                    default: aluop = ALU_ADD;
                endcase
            end
            S_IMMWB:   regwrite = 1'b1;
            S_BR: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                if (op == OP_JAL) begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                end
            end
            S_JR: begin
                pcsrc   = 2'b11;
                pcwrite = 1'b1;
            end
            S_FPSTART: begin
                fpu_start   = 1'b1;
                fpu_control = {funct[1:0], 2'b11};
            end
            S_FPWB:    fp_regwrite = 1'b1;
            default: ;
        endcase

        // A strobe in the reset cycle would commit a half-finished
        // instruction, so all side-effecting outputs are suppressed.
        if (reset) begin
            pcwrite     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            fp_regwrite = 1'b0;
            fpu_start   = 1'b0;
            fpu_control = 4'b0000;
            branch      = 1'b0;
        end
    end

    // Branch resolution uses the live zero flag; bne inverts the sense.
    assign pcen = pcwrite | (branch & (zero ^ (op == OP_BNE)));

endmodule

// File: tb/tb_multicycle_maindec.sv
module tb_multicycle_maindec;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       fpu_done;
    logic       pcwrite, pcen, iord, memwrite, irwrite;
    logic [1:0] regdst;
    logic       memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       fpu_start;
    logic [3:0] fpu_control;
    logic       fp_regwrite, illegal, fp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       pcwrite;
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
        logic       fpu_start;
        logic [3:0] fpu_control;
        logic       fp_regwrite;
    } ctrl_t;

    ctrl_t cur;
    assign cur = {pcwrite, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, zeroext, pcsrc, aluop, fpu_start, fpu_control, fp_regwrite};

    multicycle_maindec #(.MEM_WAIT(1), .FP_TIMEOUT(8), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .fpu_done(fpu_done),
        .pcwrite(pcwrite), .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop),
        .fpu_start(fpu_start), .fpu_control(fpu_control), .fp_regwrite(fp_regwrite),
        .illegal(illegal), .fp_err(fp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t fetch_c(input bit last);
        ctrl_t c = '0;
        c.alusrcb = 2'b01;
        if (last) begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.pcen    = 1'b1;
        end
        return c;
    endfunction

    function automatic ctrl_t decode_c();
        ctrl_t c = '0;
        c.alusrcb = 2'b11;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; fpu_done = 1'b0;
        step();
        step();
        checks++;
        if (cur !== fetch_c(0)) begin
            failures++;
            $display("FAIL reset_ctrl got=%h exp=%h", cur, fetch_c(0));
        end
        checks++;
        if ({illegal, fp_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00", {illegal, fp_err});
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        ctrl_t e[7];
        op = 6'b100011; funct = 6'd0;
        e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
        e[3] = '0; e[3].alusrca = 1'b1; e[3].alusrcb = 2'b10;
        e[4] = '0; e[4].iord = 1'b1;
        e[5] = e[4];
        e[6] = '0; e[6].regwrite = 1'b1; e[6].memtoreg = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cur !== e[i]) begin
                failures++;
                $display("FAIL lw cyc%0d got=%h exp=%h", i, cur, e[i]);
            end
            step();
        end
    endtask

    task automatic test_sw();
        ctrl_t e[6];
        op = 6'b101011; funct = 6'd0;
        e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
        e[3] = '0; e[3].alusrca = 1'b1; e[3].alusrcb = 2'b10;
        e[4] = '0; e[4].iord = 1'b1;
        e[5] = e[4]; e[5].memwrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cur !== e[i]) begin
                failures++;
                $display("FAIL sw cyc%0d got=%h exp=%h", i, cur, e[i]);
            end
            step();
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[3]   = '{6'b000100, 6'b000101, 6'b000100};
        logic       zeros[3] = '{1'b1, 1'b1, 1'b0};
        logic       taken[3] = '{1'b1, 1'b0, 1'b0};
        ctrl_t e[4];
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct = 6'd0; zero = zeros[k];
            e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
            e[3] = '0; e[3].alusrca = 1'b1; e[3].aluop = 4'b0001; e[3].pcsrc = 2'b01;
            e[3].pcen = taken[k];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cur !== e[i]) begin
                    failures++;
                    $display("FAIL branch%0d cyc%0d got=%h exp=%h", k, i, cur, e[i]);
                end
                step();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        ctrl_t e[5];
        op = 6'b000000; funct = 6'b100000;
        e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
        e[3] = '0; e[3].alusrca = 1'b1; e[3].aluop = 4'b1111;
        e[4] = '0; e[4].regdst = 2'b01; e[4].regwrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cur !== e[i]) begin
                failures++;
                $display("FAIL rtype cyc%0d got=%h exp=%h", i, cur, e[i]);
            end
            step();
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops[3]  = '{6'b001000, 6'b001101, 6'b001100};
        logic [3:0] alus[3] = '{4'b0000, 4'b0011, 4'b0111};
        logic       zext[3] = '{1'b0, 1'b1, 1'b1};
        ctrl_t e[5];
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct = 6'd0;
            e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
            e[3] = '0; e[3].alusrca = 1'b1; e[3].alusrcb = 2'b10;
            e[3].aluop = alus[k]; e[3].zeroext = zext[k];
            e[4] = '0; e[4].regwrite = 1'b1;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (cur !== e[i]) begin
                    failures++;
                    $display("FAIL imm%0d cyc%0d got=%h exp=%h", k, i, cur, e[i]);
                end
                step();
            end
        end
    endtask

    task automatic test_jumps();
        logic [5:0] ops[3]    = '{6'b000011, 6'b000010, 6'b000000};
        logic [5:0] functs[3] = '{6'd0, 6'd0, 6'b001000};
        ctrl_t e[4];
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct = functs[k];
            e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
            e[3] = '0; e[3].pcwrite = 1'b1; e[3].pcen = 1'b1;
            e[3].pcsrc = (k == 2) ? 2'b11 : 2'b10;
            if (k == 0) begin
                e[3].regwrite = 1'b1;
                e[3].regdst   = 2'b10;
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cur !== e[i]) begin
                    failures++;
                    $display("FAIL jump%0d cyc%0d got=%h exp=%h", k, i, cur, e[i]);
                end
                step();
            end
        end
    endtask

    task automatic fp_front(input string name);
        ctrl_t e[4];
        op = 6'b010001; funct = 6'b000010;
        e[0] = fetch_c(0); e[1] = fetch_c(1); e[2] = decode_c();
        e[3] = '0; e[3].fpu_start = 1'b1; e[3].fpu_control = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cur !== e[i]) begin
                failures++;
                $display("FAIL %s cyc%0d got=%h exp=%h", name, i, cur, e[i]);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_fp();
        ctrl_t e;
        fp_front("fp_front");
        fpu_done = 1'b1;            // pulse during FPSTART must be ignored
        step();
        fpu_done = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (cur !== ctrl_t'(0)) begin
                failures++;
                $display("FAIL fp_wait t+%0d got=%h exp=0", i, cur);
            end
            if (i == 5) fpu_done = 1'b1;
            step();
        end
        fpu_done = 1'b0;
        e = '0; e.fp_regwrite = 1'b1;
        checks++;
        if (cur !== e) begin
            failures++;
            $display("FAIL fp_wb got=%h exp=%h", cur, e);
        end
        step();
        checks++;
        if (cur !== fetch_c(0) || fp_err !== 1'b0) begin
            failures++;
            $display("FAIL fp_after got=%h err=%b exp=%h err=0", cur, fp_err, fetch_c(0));
        end
    endtask

`ifdef FP_TIMEOUT_EN
    task automatic test_fp_timeout();
        ctrl_t e;
        // fpu_done in the last allowed cycle wins over the abort
        fp_front("fp_edge_front");
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cur !== ctrl_t'(0) || fp_err !== 1'b0) begin
                failures++;
                $display("FAIL fp_edge_wait%0d got=%h err=%b exp=0 err=0", i, cur, fp_err);
            end
            if (i == 7) fpu_done = 1'b1;
            step();
        end
        fpu_done = 1'b0;
        e = '0; e.fp_regwrite = 1'b1;
        checks++;
        if (cur !== e || fp_err !== 1'b0) begin
            failures++;
            $display("FAIL fp_edge_wb got=%h err=%b exp=%h err=0", cur, fp_err, e);
        end
        step();
        // no fpu_done at all: abort after 8 FPWAIT cycles
        fp_front("fp_to_front");
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cur !== ctrl_t'(0) || fp_err !== 1'b0) begin
                failures++;
                $display("FAIL fp_to_wait%0d got=%h err=%b exp=0 err=0", i, cur, fp_err);
            end
            step();
        end
        checks++;
        if (cur !== fetch_c(0) || fp_err !== 1'b1) begin
            failures++;
            $display("FAIL fp_timeout got=%h err=%b exp=%h err=1", cur, fp_err, fetch_c(0));
        end
        step();
        checks++;
        if (cur !== fetch_c(1) || fp_err !== 1'b1) begin
            failures++;
            $display("FAIL fp_err_sticky got=%h err=%b exp=%h err=1", cur, fp_err, fetch_c(1));
        end
        step();
    endtask
`endif

    task automatic test_illegal();
        op = 6'b111111; funct = 6'd0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cur !== ((i == 2) ? decode_c() : fetch_c(i == 1))) begin
                failures++;
                $display("FAIL ill_front cyc%0d got=%h", i, cur);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cur !== ctrl_t'(0) || illegal !== 1'b1) begin
                failures++;
                $display("FAIL ill_hold%0d got=%h ill=%b exp=0 ill=1", i, cur, illegal);
            end
            step();
        end
        // reset out of ILL, then hold reset through a FETCH wait cycle
        reset = 1'b1;
        step();
        checks++;
        if (cur !== fetch_c(0) || illegal !== 1'b0) begin
            failures++;
            $display("FAIL ill_reset got=%h ill=%b exp=%h ill=0", cur, illegal, fetch_c(0));
        end
        step();
        checks++;
        if (cur !== fetch_c(0)) begin
            failures++;
            $display("FAIL reset_fetch_wait got=%h exp=%h", cur, fetch_c(0));
        end
        reset = 1'b0;
        step();
        checks++;
        if (cur !== fetch_c(1)) begin
            failures++;
            $display("FAIL fetch_last got=%h exp=%h", cur, fetch_c(1));
        end
        reset = 1'b1;               // strobes must be suppressed in the reset cycle
        #1;
        checks++;
        if (cur !== fetch_c(0)) begin
            failures++;
            $display("FAIL reset_strobe got=%h exp=%h", cur, fetch_c(0));
        end
        step();
        checks++;
        if (cur !== fetch_c(0)) begin
            failures++;
            $display("FAIL reset_cnt_clear got=%h exp=%h", cur, fetch_c(0));
        end
        reset = 1'b0;
        // FP opcode with funct >= 4 is illegal
        op = 6'b010001; funct = 6'b000100;
        step();
        step();
        checks++;
        if (cur !== decode_c()) begin
            failures++;
            $display("FAIL fp_ill_decode got=%h exp=%h", cur, decode_c());
        end
        step();
        checks++;
        if (cur !== ctrl_t'(0) || illegal !== 1'b1) begin
            failures++;
            $display("FAIL fp_ill got=%h ill=%b exp=0 ill=1", cur, illegal);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({illegal, fp_err} !== 2'b00) begin
            failures++;
            $display("FAIL final_flags got=%b exp=00", {illegal, fp_err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_imm();
        test_jumps();
        test_fp();
`ifdef FP_TIMEOUT_EN
        test_fp_timeout();
`endif
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
